qam_hard_slicer_packer: RTL and testbench

Hard-decision QAM slicer that sits directly upstream of the demapper FIFO and its controller. It accepts signed I/Q samples, makes a per-axis decision to a square-QAM constellation point, and Gray-demaps that point to bits. It packs the bit stream MSB-first into WORD_W-bit words and writes them into the FIFO with fifo_winc, honouring wfull backpressure and the controller's write_enable.

---
 rtl/qam_hard_slicer_packer_pkg.sv | 16 +
 rtl/qam_hard_slicer_packer_if.sv | 23 ++
 rtl/qam_axis_slicer.sv | 49 ++++
 rtl/qam_hard_slicer_packer.sv | 153 +++++++++++++++
 tb/tb_qam_hard_slicer_packer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qam_hard_slicer_packer_pkg.sv
// Shared constants and helpers for the QAM hard-decision slicer and demapper.
package qam_demapper_pkg;

    localparam int BPS_QPSK  = 2;
    localparam int BPS_QAM16 = 4;
    localparam int BPS_QAM64 = 6;

    function automatic int levels_per_axis(input int bps);
        return 1 << (bps / 2);
    endfunction

    function automatic logic [7:0] gray_encode(input logic [7:0] value);
        return value ^ (value >> 1);
    endfunction

endpackage

// File: rtl/qam_hard_slicer_packer_if.sv
// Sample stream in, FIFO write port out; slave is the slicer side.
interface qam_hard_slicer_packer_if #(
    parameter int SAMPLE_W = 8,
    parameter int WORD_W   = 12
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [SAMPLE_W-1:0] i_sample;
    logic signed [SAMPLE_W-1:0] q_sample;
    logic                       wfull;
    logic [WORD_W-1:0]          fifo_wdata;
    logic                       fifo_winc;

    modport master (
        output in_valid, i_sample, q_sample, wfull,
        input  in_ready, fifo_wdata, fifo_winc
    );

    modport slave (
        input  in_valid, i_sample, q_sample, wfull,
        output in_ready, fifo_wdata, fifo_winc
    );
endinterface

// File: rtl/qam_axis_slicer.sv
// Single-axis hard decision: threshold, clamp to the outer levels, Gray map.
// The decision index is registered; Gray mapping is applied to the held index.
module qam_axis_slicer
    import qam_demapper_pkg::*;
#(
    parameter int SAMPLE_W   = 8,
    parameter int BPS        = 4,
    parameter int SCALE_LOG2 = 4
) (
    input  logic                       dclk,
    input  logic                       reset,
    input  logic                       load,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic [BPS/2-1:0]           gray
);
    localparam int IDX_W = BPS / 2;
    localparam int SUM_W = SAMPLE_W + 2;
    localparam int L     = levels_per_axis(BPS);

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] level;
    logic [IDX_W-1:0]        idx_next;
    logic [IDX_W-1:0]        idx;

    // Offsetting by L half-spacings makes the lowest decision region start at 0,
    // so the arithmetic shift rounds ties upward.
    always_comb begin
        sum   = SUM_W'(sample) + SUM_W'(L << SCALE_LOG2);
        level = sum >>> (SCALE_LOG2 + 1);
        if (level[SUM_W-1]) begin
            idx_next = '0;
        end else if (level > SUM_W'(L - 1)) begin
            idx_next = IDX_W'(L - 1);
        end else begin
            idx_next = level[IDX_W-1:0];
        end
    end

    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (load) begin
            idx <= idx_next;
        end
    end

    assign gray = IDX_W'(gray_encode(8'(idx)));

endmodule

// File: rtl/qam_hard_slicer_packer.sv
// Hard-decision QAM slicer: slices I/Q, Gray-demaps, and packs bits MSB-first
// into WORD_W-bit FIFO words with wfull backpressure and a flush on enable fall.
module qam_hard_slicer_packer
    import qam_demapper_pkg::*;
#(
    parameter int SAMPLE_W   = 8,
    parameter int BPS        = 4,
    parameter int SCALE_LOG2 = 4,
    parameter int WORD_W     = 12
) (
    input  logic                    dclk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    write_enable,
    qam_hard_slicer_packer_if.slave bus,
    output logic [15:0]             drop_cnt
);
    localparam int IDX_W = BPS / 2;
    localparam int ACC_W = WORD_W + BPS - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    generate
        if (BPS != BPS_QPSK && BPS != BPS_QAM16 && BPS != BPS_QAM64) begin : g_bad_bps
            $error("qam_hard_slicer_packer: unsupported BPS");
        end
    endgenerate

    logic [0:0]        state;
    logic              alive;
    logic              s1_valid;
    logic              s2_valid;
    logic [BPS-1:0]    s2_bits;
    logic [IDX_W-1:0]  gray_i;
    logic [IDX_W-1:0]  gray_q;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_app;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_app;
    logic              word_pending;
    logic [WORD_W-1:0] word_reg;
    logic              stall;
    logic              in_ready;
    logic              accept;
    logic              take;
    logic              drained;
    logic              word_full;
    logic              flush_now;
    logic              winc;

    assign stall     = word_pending && bus.wfull;
    assign in_ready  = alive && enable && !stall && (state == ST_RUN);
    assign accept    = bus.in_valid && in_ready;
    assign take      = accept && write_enable;
    assign drained   = !s1_valid && !s2_valid;
    assign winc      = word_pending && !bus.wfull;
    assign flush_now = (state == ST_FLUSH) && drained && (cnt != '0);

    assign bus.in_ready   = in_ready;
    assign bus.fifo_winc  = winc;
    assign bus.fifo_wdata = word_reg;

    qam_axis_slicer #(.SAMPLE_W(SAMPLE_W), .BPS(BPS), .SCALE_LOG2(SCALE_LOG2)) u_slice_i (
        .dclk   (dclk),
        .reset  (reset),
        .load   (take),
        .sample (bus.i_sample),
        .gray   (gray_i)
    );

    qam_axis_slicer #(.SAMPLE_W(SAMPLE_W), .BPS(BPS), .SCALE_LOG2(SCALE_LOG2)) u_slice_q (
        .dclk   (dclk),
        .reset  (reset),
        .load   (take),
        .sample (bus.q_sample),
        .gray   (gray_q)
    );

    // Valid bits sit left-aligned in acc; cnt never exceeds WORD_W-1 between cycles.
    always_comb begin
        acc_app = acc;
        cnt_app = cnt;
        if (s2_valid) begin
            acc_app = acc | (ACC_W'(s2_bits) << (ACC_W - BPS - int'(cnt)));
            cnt_app = cnt + CNT_W'(BPS);
        end
    end

    assign word_full = cnt_app >= CNT_W'(WORD_W);

    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            alive        <= 1'b0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s2_bits      <= '0;
            acc          <= '0;
            cnt          <= '0;
            word_pending <= 1'b0;
            word_reg     <= '0;
        end else begin
            alive <= 1'b1;
            if (winc) begin
                word_pending <= 1'b0;
            end
            if (!stall) begin
                s1_valid <= take;
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_bits <= {gray_i, gray_q};
                end
                if (word_full) begin
                    word_reg     <= acc_app[ACC_W-1 -: WORD_W];
                    word_pending <= 1'b1;
                    acc          <= acc_app << WORD_W;
                    cnt          <= cnt_app - CNT_W'(WORD_W);
                end else if (flush_now) begin
                    word_reg     <= acc[ACC_W-1 -: WORD_W];
                    word_pending <= 1'b1;
                    acc          <= '0;
                    cnt          <= '0;
                end else begin
                    acc <= acc_app;
                    cnt <= cnt_app;
                end
            end
        end
    end

    // Once a flush starts it runs to completion even if enable comes back.
    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else if (state == ST_RUN) begin
            if (!enable && alive && (!drained || cnt != '0)) begin
                state <= ST_FLUSH;
            end
        end else if (drained && (cnt == '0 || !stall)) begin
            state <= ST_RUN;
        end
    end

    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (accept && !write_enable && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_qam_hard_slicer_packer.sv
// Scoreboard bench: directed samples push hand-computed words; a negedge
// monitor pops and compares every FIFO write from two DUT configurations.
module tb_qam_hard_slicer_packer;

    logic        dclk = 1'b0;
    logic        rst_n;
    logic        en_a;
    logic        we_a;
    logic        en_b;
    logic        we_b;
    logic [15:0] drop_a;
    logic [15:0] drop_b;

    int checks  = 0;
    int errors  = 0;
    int wincs_b = 0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    qam_hard_slicer_packer_if #(.SAMPLE_W(8), .WORD_W(12)) bus_a ();
    qam_hard_slicer_packer_if #(.SAMPLE_W(8), .WORD_W(8))  bus_b ();

    qam_hard_slicer_packer dut_a (
        .dclk         (dclk),
        .reset        (rst_n),
        .enable       (en_a),
        .write_enable (we_a),
        .bus          (bus_a),
        .drop_cnt     (drop_a)
    );

    qam_hard_slicer_packer #(.SAMPLE_W(8), .BPS(6), .SCALE_LOG2(4), .WORD_W(8)) dut_b (
        .dclk         (dclk),
        .reset        (rst_n),
        .enable       (en_b),
        .write_enable (we_b),
        .bus          (bus_b),
        .drop_cnt     (drop_b)
    );

    always #5 dclk = ~dclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every FIFO write must match the head of that DUT's queue.
    always @(negedge dclk) begin
        if (bus_a.fifo_winc === 1'b1) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word_a actual=%0h expected=none", bus_a.fifo_wdata);
            end else begin
                checkOutput("word_a", 32'(bus_a.fifo_wdata), exp_a.pop_front());
            end
        end
        if (bus_b.fifo_winc === 1'b1) begin
            wincs_b++;
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word_b actual=%0h expected=none", bus_b.fifo_wdata);
            end else begin
                checkOutput("word_b", 32'(bus_b.fifo_wdata), exp_b.pop_front());
            end
        end
    end

    task automatic applyStimulus(input bit to_b, input logic signed [7:0] i_val, input logic signed [7:0] q_val);
        int waited;
        logic rdy;
        waited = 0;
        if (to_b) begin
            bus_b.i_sample = i_val;
            bus_b.q_sample = q_val;
            bus_b.in_valid = 1'b1;
        end else begin
            bus_a.i_sample = i_val;
            bus_a.q_sample = q_val;
            bus_a.in_valid = 1'b1;
        end
        @(negedge dclk);
        rdy = to_b ? bus_b.in_ready : bus_a.in_ready;
        while (rdy !== 1'b1 && waited < 40) begin
            waited++;
            @(negedge dclk);
            rdy = to_b ? bus_b.in_ready : bus_a.in_ready;
        end
        checkOutput("accept_ready", 32'(rdy), 32'd1);
        @(posedge dclk);
        #1;
        if (to_b) bus_b.in_valid = 1'b0;
        else bus_a.in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 60) begin
            @(negedge dclk);
            n++;
        end
        checkOutput(name, 32'(exp_a.size() + exp_b.size()), 32'd0);
        @(posedge dclk);
        #1;
    endtask

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n          = 1'b0;
        en_a           = 1'b1;
        we_a           = 1'b1;
        en_b           = 1'b1;
        we_b           = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.i_sample = '0;
        bus_a.q_sample = '0;
        bus_a.wfull    = 1'b0;
        bus_b.in_valid = 1'b0;
        bus_b.i_sample = '0;
        bus_b.q_sample = '0;
        bus_b.wfull    = 1'b0;

        #12;
        $display("[TB] reset state");
        checkOutput("rst_in_ready_a", 32'(bus_a.in_ready), 32'd0);
        checkOutput("rst_winc_a", 32'(bus_a.fifo_winc), 32'd0);
        checkOutput("rst_wdata_a", 32'(bus_a.fifo_wdata), 32'd0);
        checkOutput("rst_drop_a", 32'(drop_a), 32'd0);
        checkOutput("rst_in_ready_b", 32'(bus_b.in_ready), 32'd0);
        bus_a.in_valid = 1'b0;
        @(posedge dclk);
        #3 rst_n = 1'b1;
        @(posedge dclk);
        #1;

        $display("[TB] test 1: three QAM16 symbols into one word");
        exp_a.push_back(32'h999);
        repeat (3) applyStimulus(1'b0, 8'sd48, -8'sd16);
        @(negedge dclk);
        checkOutput("latency_n0", 32'(bus_a.fifo_winc), 32'd0);
        @(negedge dclk);
        checkOutput("latency_n1", 32'(bus_a.fifo_winc), 32'd0);
        @(negedge dclk);
        checkOutput("latency_n2", 32'(bus_a.fifo_winc), 32'd1);
        waitDrain("drain_t1");

        $display("[TB] test 2: clamp, tie and flush");
        exp_a.push_back(32'h8D0);
        applyStimulus(1'b0, 8'sd127, -8'sd128);
        applyStimulus(1'b0, 8'sd0, -8'sd32);
        en_a = 1'b0;
        waitDrain("drain_t2");
        en_a = 1'b1;

        $display("[TB] test 3: QAM64 into 8-bit words");
        exp_b.push_back(32'h82);
        exp_b.push_back(32'h08);
        exp_b.push_back(32'h20);
        repeat (4) applyStimulus(1'b1, 8'sd112, -8'sd112);
        waitDrain("drain_t3");
        en_b = 1'b0;
        repeat (10) @(negedge dclk);
        checkOutput("flush_empty_b", 32'(wincs_b), 32'd3);
        @(posedge dclk);
        #1;

        $display("[TB] test 4: wfull backpressure");
        exp_a.push_back(32'h2F2);
        exp_a.push_back(32'hF2F);
        bus_a.wfull = 1'b1;
        applyStimulus(1'b0, -8'sd48, 8'sd80);
        applyStimulus(1'b0, 8'sd16, 8'sd16);
        applyStimulus(1'b0, -8'sd48, 8'sd80);
        applyStimulus(1'b0, 8'sd16, 8'sd16);
        applyStimulus(1'b0, -8'sd48, 8'sd80);
        bus_a.i_sample = 8'sd16;
        bus_a.q_sample = 8'sd16;
        bus_a.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge dclk);
            checkOutput("stall_in_ready", 32'(bus_a.in_ready), 32'd0);
            checkOutput("stall_wdata", 32'(bus_a.fifo_wdata), 32'h2F2);
            checkOutput("stall_winc", 32'(bus_a.fifo_winc), 32'd0);
        end
        @(posedge dclk);
        #1;
        bus_a.wfull = 1'b0;
        @(negedge dclk);
        checkOutput("release_in_ready", 32'(bus_a.in_ready), 32'd1);
        @(posedge dclk);
        #1;
        bus_a.in_valid = 1'b0;
        waitDrain("drain_t4");

        $display("[TB] test 5: write_enable low drops symbols");
        exp_a.push_back(32'h2FF);
        applyStimulus(1'b0, -8'sd48, 8'sd80);
        we_a = 1'b0;
        repeat (5) applyStimulus(1'b0, -8'sd112, -8'sd112);
        checkOutput("drop_cnt_5", 32'(drop_a), 32'd5);
        we_a = 1'b1;
        applyStimulus(1'b0, 8'sd16, 8'sd16);
        applyStimulus(1'b0, 8'sd16, 8'sd16);
        waitDrain("drain_t5");
        checkOutput("drop_cnt_hold", 32'(drop_a), 32'd5);

        $display("[TB] test 6: reset with partial bits and a pending word");
        en_b = 1'b1;
        bus_b.wfull = 1'b1;
        applyStimulus(1'b1, 8'sd112, -8'sd112);
        applyStimulus(1'b1, 8'sd112, -8'sd112);
        repeat (3) @(negedge dclk);
        #1 bus_b.wfull = 1'b0;
        #1;
        checkOutput("pre_rst_winc_b", 32'(bus_b.fifo_winc), 32'd1);
        checkOutput("pre_rst_wdata_b", 32'(bus_b.fifo_wdata), 32'h82);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_winc_b", 32'(bus_b.fifo_winc), 32'd0);
        checkOutput("mid_rst_wdata_b", 32'(bus_b.fifo_wdata), 32'd0);
        checkOutput("mid_rst_in_ready_b", 32'(bus_b.in_ready), 32'd0);
        checkOutput("mid_rst_drop_a", 32'(drop_a), 32'd0);
        checkOutput("mid_rst_in_ready_a", 32'(bus_a.in_ready), 32'd0);
        repeat (2) @(posedge dclk);
        #3 rst_n = 1'b1;
        @(posedge dclk);
        #1;
        exp_b.push_back(32'h10);
        exp_b.push_back(32'h41);
        exp_b.push_back(32'h04);
        repeat (4) applyStimulus(1'b1, -8'sd112, 8'sd112);
        waitDrain("drain_t6");
        checkOutput("wincs_b_total", 32'(wincs_b), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
